// File: rtl/apmu_rf_ctx_seq.sv
// -----------------------------------------------------------------------------
// apmu_rf_ctx_seq
//
// Context save/restore sequencer that sits between the core and the
// latch-based integer register file. When idle, the core read and write
// ports pass straight through. On a request, the sequencer stalls the core and
// takes over the register file. It then does one of two things:
//   - SAVE: streams x1..xLAST out over a valid/ready port.
//   - RESTORE: writes x1..xLAST from a valid/ready input stream.
//
// Optional build macro:
//   APMU_RF_CTX_CSUM_EN - adds ctx_csum_o, the running XOR of every word
//                         handshaken during the last SAVE or RESTORE.
//
// Parameters:
//   RV32E     - 1: 16-entry file (x1..x15), 0: 32-entry file (x1..x31)
//   DataWidth - register word width
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   save_req_i, restore_req_i   level requests, sampled in IDLE only
//   busy_o, done_o              not-idle flag, one-cycle completion pulse
//   core_stall_o                core must hold its pipeline
//   core_* (inputs)             core register file port
//   rf_* (outputs), rf_rdata_a_i  register file port (read data is comb.)
//   save_valid_o/ready_i/data_o/idx_o  save stream (source)
//   rest_valid_i/ready_o/data_i        restore stream (sink)
//   ctx_csum_o                  XOR checksum (APMU_RF_CTX_CSUM_EN only)
// -----------------------------------------------------------------------------
module apmu_rf_ctx_seq #(
  parameter int unsigned RV32E     = 0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 save_req_i,
  input  logic                 restore_req_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 core_stall_o,
  input  logic [4:0]           core_raddr_a_i,
  input  logic [4:0]           core_raddr_b_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic                 core_we_i,
  output logic [4:0]           rf_raddr_a_o,
  output logic [4:0]           rf_raddr_b_o,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 save_valid_o,
  input  logic                 save_ready_i,
  output logic [DataWidth-1:0] save_data_o,
  output logic [4:0]           save_idx_o,
  input  logic                 rest_valid_i,
  output logic                 rest_ready_o,
  input  logic [DataWidth-1:0] rest_data_i
`ifdef APMU_RF_CTX_CSUM_EN
  ,
  output logic [DataWidth-1:0] ctx_csum_o
`endif
);

  localparam logic [4:0] LAST = (RV32E != 0) ? 5'd15 : 5'd31;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SAVE,
    RESTORE,
    FLUSH
  } state_e;

  state_e     state_q;
  logic [4:0] idx_q;
  logic       done_q;

  logic save_hs;
  logic rest_hs;

  assign save_hs = (state_q == SAVE) && save_ready_i;
  assign rest_hs = (state_q == RESTORE) && rest_valid_i;

  // ---- sequencer state: idx always returns to 1 outside an active stream
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= 5'd1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          idx_q <= 5'd1;
          if (save_req_i) begin
            state_q <= DRAIN;
          end else if (restore_req_i) begin
            state_q <= RESTORE;
          end
        end
        DRAIN: begin
          // Lets a core write from the accept cycle settle in its latch
          // before the first sequencer read.
          idx_q   <= 5'd1;
          state_q <= SAVE;
        end
        SAVE: begin
          if (save_ready_i) begin
            if (idx_q == LAST) begin
              idx_q   <= 5'd1;
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        RESTORE: begin
          if (rest_valid_i) begin
            if (idx_q == LAST) begin
              idx_q   <= 5'd1;
              state_q <= FLUSH;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= 5'd1;
        end
      endcase
    end
  end

  // ---- register file port mux and stream outputs
  always_comb begin
    busy_o       = (state_q != IDLE);
    done_o       = done_q;
    core_stall_o = 1'b1;
    rf_raddr_a_o = 5'd0;
    rf_raddr_b_o = 5'd0;
    rf_waddr_o   = 5'd0;
    rf_wdata_o   = '0;
    rf_we_o      = 1'b0;
    save_valid_o = 1'b0;
    save_data_o  = '0;
    save_idx_o   = idx_q;
    rest_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        core_stall_o = save_req_i | restore_req_i;
        rf_raddr_a_o = core_raddr_a_i;
        rf_raddr_b_o = core_raddr_b_i;
        rf_waddr_o   = core_waddr_i;
        rf_wdata_o   = core_wdata_i;
        rf_we_o      = core_we_i;
      end
      SAVE: begin
        rf_raddr_a_o = idx_q;
        save_valid_o = 1'b1;
        save_data_o  = rf_rdata_a_i;
      end
      RESTORE: begin
        rest_ready_o = 1'b1;
        rf_we_o      = rest_valid_i;
        rf_waddr_o   = idx_q;
        rf_wdata_o   = rest_data_i;
      end
      default: begin
      end
    endcase
  end

`ifdef APMU_RF_CTX_CSUM_EN
  // ---- checksum: cleared when an operation is accepted, held in IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctx_csum_o <= '0;
    end else if ((state_q == IDLE) && (save_req_i || restore_req_i)) begin
      ctx_csum_o <= '0;
    end else if (save_hs) begin
      ctx_csum_o <= ctx_csum_o ^ rf_rdata_a_i;
    end else if (rest_hs) begin
      ctx_csum_o <= ctx_csum_o ^ rest_data_i;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = save_hs ^ rest_hs;
`endif

endmodule
